// File: rtl/fp_sq_pkg.sv
// Shared definitions for the iterative floating-point squarer.
// Latency: n/a (types, constants and elaboration-time helper functions only).
// Backpressure: n/a.
// Contents: FSM state encodings, flag bit positions, and format helpers
// (bias, all-ones exponent, canonical quiet NaN) parametrised by field widths.
package fp_sq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BOOTH = 2'd1;
  localparam state_t ST_NORM  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bit positions inside the {ovf, unf, inx} flag vector.
  localparam int OVF = 2;
  localparam int UNF = 1;
  localparam int INX = 0;

  function automatic int f_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Helpers return a wide vector; callers size-cast to their field width.
  function automatic logic [63:0] f_exp_ones(input int exp_w);
    return (64'd1 << exp_w) - 64'd1;
  endfunction

  // Canonical qNaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] f_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_square_iter_booth.sv
// Radix-4 Booth partial-product generator (one digit).
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: digit - 3-bit Booth window {b[2i+1], b[2i], b[2i-1]};
//        sig   - unsigned multiplicand; pp - two's-complement 0, +-S or +-2S,
//        sign-extended to PP_W bits and not yet shifted into position.
module booth_r4_pp #(
  parameter int SIG_W = 11,
  parameter int PP_W  = 24
) (
  input  logic [2:0]       digit,
  input  logic [SIG_W-1:0] sig,
  output logic [PP_W-1:0]  pp
);

  logic [PP_W-1:0] s1;
  logic [PP_W-1:0] s2;

  always_comb begin
    s1 = PP_W'(sig);
    s2 = s1 << 1;
    pp = '0;
    case (digit)
      3'b001, 3'b010: pp = s1;
      3'b011:         pp = s2;
      3'b100:         pp = -s2;
      3'b101, 3'b110: pp = -s1;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/fp_square_iter.sv
// Sequential IEEE-754-style squarer: radix-4 Booth significand product, RNE rounding.
// Latency: normal operand -> out_valid 8 cycles after the acceptance cycle (binary16);
//          zero/subnormal/inf/NaN -> out_valid the cycle after acceptance.
// Backpressure: one operation in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data {sign,exp,frac};
//        out_valid/out_ready/out_data (squared value); out_flags {ovf, unf, inx}.
module fp_square_iter
  import fp_sq_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [2:0]             out_flags
);

  localparam int BIAS  = f_bias(EXP_W);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int P_W   = 2 * SIG_W;
  localparam int ACC_W = 2 * SIG_W + 2;
  localparam int N_DIG = (MAN_W + 3) / 2;
  localparam int MUL_W = 2 * N_DIG + 1;       // zero-extended significand plus sig[-1]
  localparam int PAD   = MUL_W - SIG_W - 1;
  localparam int CNT_W = $clog2(N_DIG);
  localparam int ER_W  = EXP_W + 2;

  localparam logic [CNT_W-1:0]       LAST_DIG = CNT_W'(N_DIG - 1);
  localparam logic [EXP_W-1:0]       EXP_ONES = EXP_W'(f_exp_ones(EXP_W));
  localparam logic [W-1:0]           QNAN     = W'(f_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]           PINF     = {1'b0, EXP_ONES, {MAN_W{1'b0}}};
  localparam logic signed [ER_W-1:0] ER_OVF   = ER_W'((1 << EXP_W) - 1);
  localparam logic signed [ER_W-1:0] ER_ZERO  = '0;

  state_t             state;
  logic [SIG_W-1:0]   sig_q;
  logic [MUL_W-1:0]   mul_q;
  logic [EXP_W-1:0]   exp_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [EXP_W-1:0]   in_exp;
  logic [MAN_W-1:0]   in_frac;
  logic [ACC_W-1:0]   pp;

  logic [P_W-1:0]     p;
  logic [P_W-1:0]     pn;
  logic               norm;
  logic [MAN_W-1:0]   kept;
  logic               g_bit;
  logic               s_bit;
  logic               rnd;
  logic [MAN_W:0]     man_r;
  logic signed [ER_W-1:0] e_r;
  logic [W-1:0]       res_data;
  logic [2:0]         res_flags;
  logic               unused_bits;

  assign in_exp    = in_data[W-2 -: EXP_W];
  assign in_frac   = in_data[MAN_W-1:0];
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Sign is irrelevant to a square; the accumulator headroom above the
  // product and the normalised leading one are never read.
  assign unused_bits = ^{in_data[W-1], acc_q[ACC_W-1:P_W], pn[P_W-1]};

  booth_r4_pp #(
    .SIG_W (SIG_W),
    .PP_W  (ACC_W)
  ) u_booth (
    .digit (mul_q[2:0]),
    .sig   (sig_q),
    .pp    (pp)
  );

  // Normalise and round the completed product (value p / 2^(2*MAN_W), in [1,4)).
  always_comb begin
    p     = acc_q[P_W-1:0];
    norm  = p[P_W-1];
    pn    = norm ? p : (p << 1);
    kept  = pn[P_W-2 -: MAN_W];
    g_bit = pn[MAN_W];
    s_bit = |pn[MAN_W-1:0];
    rnd   = g_bit & (s_bit | kept[0]);
    // A carry out means the fraction wrapped to zero: the low bits are already
    // the renormalised fraction, only the exponent needs the extra increment.
    man_r = {1'b0, kept} + {{MAN_W{1'b0}}, rnd};
    e_r   = ER_W'({exp_q, 1'b0}) - ER_W'(BIAS) + ER_W'(norm) + ER_W'(man_r[MAN_W]);

    res_flags = '0;
    if (e_r >= ER_OVF) begin
      res_data       = PINF;
      res_flags[OVF] = 1'b1;
      res_flags[INX] = 1'b1;
    end else if (e_r <= ER_ZERO) begin
      res_data       = '0;
      res_flags[UNF] = 1'b1;
      res_flags[INX] = 1'b1;
    end else begin
      res_data       = {1'b0, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      res_flags[INX] = g_bit | s_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sig_q     <= '0;
      mul_q     <= '0;
      exp_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_exp == '0) begin
              // Zero and subnormal inputs are flushed: the square is +0.
              out_data  <= '0;
              out_flags <= '0;
              state     <= ST_DONE;
            end else if (in_exp == EXP_ONES) begin
              out_data  <= (in_frac == '0) ? PINF : QNAN;
              out_flags <= '0;
              state     <= ST_DONE;
            end else begin
              sig_q <= {1'b1, in_frac};
              mul_q <= {{PAD{1'b0}}, 1'b1, in_frac, 1'b0};
              exp_q <= in_exp;
              acc_q <= '0;
              cnt_q <= '0;
              state <= ST_BOOTH;
            end
          end
        end
        ST_BOOTH: begin
          // Digits are consumed LSB-first; each carries weight 4^cnt.
          acc_q <= acc_q + (pp << {cnt_q, 1'b0});
          mul_q <= mul_q >> 2;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_DIG) state <= ST_NORM;
        end
        ST_NORM: begin
          out_data  <= res_data;
          out_flags <= res_flags;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_square_iter.md
Name: fp_square_iter

Overview:
- Parametrised IEEE-754-style floating-point squarer. It is the sequential successor of the FP16 combinational squaring unit.
- Computes the significand product with an iterative radix-4 Booth recoder, one digit per cycle.
- Rounds round-to-nearest-even (RNE) and reports exception flags.
- Sits behind a valid/ready stream and feeds the FP datapath result bus. Default configuration is binary16.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa (fraction) width.
- BIAS, 2**(EXP_W-1)-1, exponent bias. Derived, not overridable.
- N_DIG, (MAN_W+3)/2, number of radix-4 Booth digits. Derived: 6 for binary16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  1+EXP_W+MAN_W  operand {sign, exp, frac}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  1+EXP_W+MAN_W  squared result.
- out_flags  out  3  {ovf, unf, inx}.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_flags=0, state=IDLE. Reset asserted mid-operation abandons the operand; no output is produced for it.
- States: IDLE, BOOTH, NORM, DONE.
  - IDLE: in_ready=1. On in_valid, latch the operand, then go to DONE (special case) or BOOTH (normal operand).
  - BOOTH: one Booth digit per cycle, LSB-first, for exactly N_DIG cycles. Digit i = {sig[2i+1], sig[2i], sig[2i-1]}, with sig[-1]=0 and the significand zero-extended. The accumulator is 2*(MAN_W+1)+2 bits signed. Partial product (0, ±S, ±2S) is shifted left by 2i. Then go to NORM.
  - NORM: normalise, round, compute exponent, then go to DONE.
  - DONE: out_valid=1. out_data and out_flags are held stable until out_ready=1. On the handshake go to IDLE. in_ready=0 in every state except IDLE; no overlap of operations.
- Latency (normal operand): acceptance edge plus N_DIG plus 1. out_valid rises 8 cycles after acceptance for binary16. Throughput is one result per 9 cycles with out_ready held at 1.
- Special cases (taken in IDLE, no BOOTH) produce out_valid on the cycle after acceptance:
  - exp=0 (zero or subnormal): input flushed to zero, result +0, flags 0.
  - exp all-ones with frac=0 (±inf): result +inf, flags 0.
  - exp all-ones with frac≠0 (NaN): result canonical qNaN {0, all-ones, 1, 0...}, flags 0.
- Sign of every non-NaN result is 0.
- Arithmetic:
  - Product P = S*S, where S = {1, frac}. P lies in [1,4).
  - If P≥2, shift right 1 and set norm=1.
  - Exponent e_r = 2*e - BIAS + norm, computed in EXP_W+2 signed bits.
  - Rounding uses the kept MAN_W bits, guard bit and sticky (OR of the rest). RNE: round up if G&(S|LSB). A rounding carry out of the significand increments e_r and renormalises.
- Range after rounding:
  - e_r ≥ 2**EXP_W-1: result +inf, ovf=1, inx=1.
  - e_r ≤ 0: result +0, unf=1, inx=1. No subnormal outputs.
  - Otherwise inx = G|S.

Decomposition:
- Package fp_sq_pkg holds:
  - state enum;
  - flag bit indices OVF=2, UNF=1, INX=0;
  - functions for bias, all-ones exponent and canonical qNaN, each parametrised by EXP_W/MAN_W.
- One sub-module, booth_r4_pp: combinational. Maps a 3-bit digit plus significand to a signed, sign-extended partial product.

Test Plan:
- 0x3C00 (1.0), out_ready=1 -> 0x3C00, flags 000, out_valid exactly 8 cycles after acceptance.
- 0x3E00 (1.5) -> 0x4080 (2.25), flags 000. 0xC200 (-3.0) -> 0x4880 (9.0), flags 000 (sign cleared).
- 0x3C01 (1+2^-10) -> 0x3C02, inx=1 (RNE discards the 2^-20 term).
- 0x5C00 (256) -> 0x7C00, flags 101. 0x1400 (2^-10) -> 0x0000, flags 011.
- Special values, each with out_valid 1 cycle after acceptance and flags 000:
  - 0xFC00 -> 0x7C00;
  - 0x7D00 -> 0x7E00;
  - 0x8000 -> 0x0000;
  - 0x0001 -> 0x0000.
- Back-pressure and reset:
  - out_ready=0 for 5 cycles in DONE: out_data/out_flags stable, in_ready=0, a new in_valid is ignored.
  - rst pulse during BOOTH: out_valid=0, in_ready=1 immediately. The next operand 0x3E00 yields 0x4080.
